// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage controller between the EX->MEM and MEM->WB
// pipeline registers. Runs loads/stores on a req/ack bus, stalls the front
// of the pipeline while an access is outstanding, and flags misaligned
// addresses and bus timeouts on the instruction as it moves into WB.
module mem_stage_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    // EX->MEM register outputs
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  WriteRegM,
    // data-memory bus
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    // pipeline control
    output logic        StallM,
    // MEM->WB register
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [4:0]  WriteRegW,
    output logic        AlignErrW,
    output logic        BusErrW
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, stateNext;
    logic [CW-1:0] waitCnt;
    logic          access, misaligned, lastWait;
    logic          stall, startAcc, busErr;

    // Decode the instruction currently sitting in MEM.
    always_comb begin
        access     = MemtoRegM | MemWriteM;
        misaligned = access & (ALUOutM[1:0] != 2'b00);
        lastWait   = (waitCnt == CW'(TIMEOUT - 1));
    end

    // Next-state and stall decision. An ack in the final wait cycle wins
    // over the timeout.
    always_comb begin
        stateNext = state;
        stall     = 1'b0;
        startAcc  = 1'b0;
        busErr    = 1'b0;
        case (state)
            IDLE: begin
                if (access && !misaligned) begin
                    stall     = 1'b1;
                    startAcc  = 1'b1;
                    stateNext = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    stateNext = IDLE;
                end else if (lastWait) begin
                    busErr    = 1'b1;
                    stateNext = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // No stall is reported while reset is held, even if MEM holds an access.
    assign StallM = stall & rst_n;

    // State register and wait counter; the counter restarts at each new access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            waitCnt <= '0;
        end else begin
            state <= stateNext;
            if (startAcc)
                waitCnt <= '0;
            else if (state == BUSY && !mem_ack)
                waitCnt <= waitCnt + 1'b1;
        end
    end

    // Bus request side: request is high exactly while in BUSY; address, data
    // and direction are captured once at the start and held for the access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_req <= (stateNext == BUSY);
            if (startAcc) begin
                mem_we    <= MemWriteM;
                mem_addr  <= {ALUOutM[31:2], 2'b00};
                mem_wdata <= WriteDataM;
            end
        end
    end

    // MEM->WB register: the instruction moves on only in a non-stall cycle;
    // stall cycles push a bubble so WB never sees the same instruction twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            ReadDataW <= '0;
            ALUOutW   <= '0;
            WriteRegW <= '0;
            AlignErrW <= 1'b0;
            BusErrW   <= 1'b0;
        end else if (stall) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            ReadDataW <= '0;
            ALUOutW   <= '0;
            WriteRegW <= '0;
            AlignErrW <= 1'b0;
            BusErrW   <= 1'b0;
        end else begin
            RegWriteW <= RegWriteM & ~misaligned & ~busErr;
            MemtoRegW <= MemtoRegM & ~misaligned;
            ReadDataW <= (state == BUSY && mem_ack && MemtoRegM) ? mem_rdata : 32'h0;
            ALUOutW   <= ALUOutM;
            WriteRegW <= WriteRegM;
            AlignErrW <= misaligned;
            BusErrW   <= busErr;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed vector table, reset and back-to-back
// sequences, then random instructions checked against a transaction model.
module tb_mem_stage_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWriteM, MemtoRegM, MemWriteM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [4:0]  WriteRegM;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        StallM;
    logic        RegWriteW, MemtoRegW, AlignErrW, BusErrW;
    logic [31:0] ReadDataW, ALUOutW;
    logic [4:0]  WriteRegW;

    mem_stage_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .StallM(StallM),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .ReadDataW(ReadDataW),
        .ALUOutW(ALUOutW), .WriteRegW(WriteRegW), .AlignErrW(AlignErrW), .BusErrW(BusErrW)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // d = number of BUSY cycles before the memory acks (>= TIMEOUT: never)
    typedef struct {
        logic        rw, mtr, mw;
        logic [31:0] addr, wdata;
        logic [4:0]  wreg;
        int          d;
        logic [31:0] rdata;
    } instr_t;

    // stall = cycles with StallM high; ALUOutW/WriteRegW always follow the instr
    typedef struct {
        int          stall;
        logic        rw, mtr;
        logic [31:0] rd;
        logic        ae, be;
    } exp_t;

    typedef struct {
        instr_t i;
        exp_t   e;
    } vec_t;

    int nChecks = 0;
    int nErr    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: whole-instruction outcome from the rules.
    function automatic exp_t model(input instr_t in);
        exp_t e;
        logic acc, mis;
        acc = in.mtr | in.mw;
        mis = acc && (in.addr[1:0] != 2'b00);
        e.ae = mis;
        e.be = 1'b0;
        e.rd = 32'h0;
        if (!acc || mis) begin
            e.stall = 0;
            e.rw    = in.rw & ~mis;
            e.mtr   = in.mtr & ~mis;
        end else if (in.d < TIMEOUT) begin
            e.stall = 1 + in.d;
            e.rw    = in.rw;
            e.mtr   = in.mtr;
            e.rd    = in.mtr ? in.rdata : 32'h0;
        end else begin
            e.stall = TIMEOUT;
            e.rw    = 1'b0;
            e.mtr   = in.mtr;
            e.be    = 1'b1;
        end
        return e;
    endfunction

    // Present one instruction (called at posedge+1), play memory, and check
    // bus fields, stall length, bubbles and the final WB contents.
    task automatic runOne(input string tag, input instr_t in, input exp_t ex, output int landCyc);
        int   stallCnt, reqCnt;
        logic s;
        bit   done;
        RegWriteM  = in.rw;  MemtoRegM = in.mtr; MemWriteM = in.mw;
        ALUOutM    = in.addr; WriteDataM = in.wdata; WriteRegM = in.wreg;
        stallCnt = 0; reqCnt = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (mem_req) begin
                chk({tag, " mem_addr"}, mem_addr, {in.addr[31:2], 2'b00});
                chk({tag, " mem_we"}, {31'b0, mem_we}, {31'b0, in.mw});
                if (in.mw) chk({tag, " mem_wdata"}, mem_wdata, in.wdata);
                mem_ack   = (reqCnt == in.d);
                mem_rdata = (reqCnt == in.d) ? in.rdata : $urandom;
                reqCnt++;
            end else begin
                mem_ack   = 1'($urandom_range(0, 1)); // must be ignored in IDLE
                mem_rdata = $urandom;
            end
            #1 s = StallM;
            @(posedge clk);
            #1 mem_ack = 1'b0;
            if (s) begin
                stallCnt++;
                chk({tag, " bubble ctl"}, {23'b0, RegWriteW, MemtoRegW, AlignErrW, BusErrW, WriteRegW}, 32'h0);
                chk({tag, " bubble data"}, ReadDataW | ALUOutW, 32'h0);
            end else begin
                done = 1;
            end
        end
        if (!done) begin
            nChecks++; nErr++;
            $display("FAIL %s stall_bound: StallM still high after 40 cycles", tag);
        end
        landCyc = cyc;
        chk({tag, " stall_cycles"}, stallCnt, ex.stall);
        chk({tag, " req_cycles"}, reqCnt, ex.stall);
        chk({tag, " req_dropped"}, {31'b0, mem_req}, 32'h0);
        chk({tag, " RegWriteW"}, {31'b0, RegWriteW}, {31'b0, ex.rw});
        chk({tag, " MemtoRegW"}, {31'b0, MemtoRegW}, {31'b0, ex.mtr});
        chk({tag, " ReadDataW"}, ReadDataW, ex.rd);
        chk({tag, " ALUOutW"}, ALUOutW, in.addr);
        chk({tag, " WriteRegW"}, {27'b0, WriteRegW}, {27'b0, in.wreg});
        chk({tag, " AlignErrW"}, {31'b0, AlignErrW}, {31'b0, ex.ae});
        chk({tag, " BusErrW"}, {31'b0, BusErrW}, {31'b0, ex.be});
    endtask

    task automatic clearInputs();
        RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0;
        ALUOutM = 0; WriteDataM = 0; WriteRegM = 0;
        mem_ack = 0; mem_rdata = 0;
    endtask

    task automatic chkWbZero(input string tag);
        chk({tag, " W ctl"}, {23'b0, RegWriteW, MemtoRegW, AlignErrW, BusErrW, WriteRegW}, 32'h0);
        chk({tag, " W data"}, ReadDataW | ALUOutW, 32'h0);
    endtask

    vec_t   vecs[9];
    instr_t ri;
    int     land1, land2, tmp;

    initial begin
        // rw mtr mw addr wdata wreg d rdata  |  stall rw mtr rd ae be
        vecs[0] = '{'{1, 0, 0, 32'h0000_1234, 32'h0, 5'd8, 0, 32'h0},        '{0, 1, 0, 32'h0, 0, 0}};
        vecs[1] = '{'{1, 1, 0, 32'h0000_0100, 32'h0, 5'd5, 3, 32'hDEAD_BEEF}, '{4, 1, 1, 32'hDEAD_BEEF, 0, 0}};
        vecs[2] = '{'{0, 0, 1, 32'h0000_0204, 32'h55AA_55AA, 5'd0, 0, 32'h0}, '{1, 0, 0, 32'h0, 0, 0}};
        vecs[3] = '{'{1, 1, 0, 32'h0000_0102, 32'h0, 5'd9, 0, 32'h0},        '{0, 0, 0, 32'h0, 1, 0}};
        vecs[4] = '{'{1, 1, 0, 32'h0000_0300, 32'h0, 5'd10, 99, 32'h0},      '{16, 0, 1, 32'h0, 0, 1}};
        vecs[5] = '{'{1, 1, 0, 32'h0000_0300, 32'h0, 5'd11, 15, 32'h1234_5678}, '{16, 1, 1, 32'h1234_5678, 0, 0}};
        vecs[6] = '{'{0, 0, 1, 32'h0000_0207, 32'hFFFF_0000, 5'd0, 0, 32'h0}, '{0, 0, 0, 32'h0, 1, 0}};
        vecs[7] = '{'{1, 0, 0, 32'h0000_0003, 32'h0, 5'd31, 0, 32'h0},       '{0, 1, 0, 32'h0, 0, 0}};
        vecs[8] = '{'{1, 1, 0, 32'hFFFF_FFFC, 32'h0, 5'd1, 14, 32'hCAFE_F00D}, '{15, 1, 1, 32'hCAFE_F00D, 0, 0}};

        // reset state
        rst_n = 1'b0;
        clearInputs();
        #2;
        chk("reset mem_req", {31'b0, mem_req}, 32'h0);
        chk("reset mem_bus", {31'b0, mem_we} | mem_addr | mem_wdata, 32'h0);
        chk("reset StallM", {31'b0, StallM}, 32'h0);
        chkWbZero("reset");
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

        // directed table
        foreach (vecs[k]) begin
            runOne($sformatf("vec%0d", k), vecs[k].i, vecs[k].e, tmp);
        end

        // back-to-back store then load, both acked at once
        runOne("b2b store", '{0, 0, 1, 32'h10, 32'hA5A5_0001, 5'd0, 0, 32'h0}, '{1, 0, 0, 32'h0, 0, 0}, land1);
        runOne("b2b load", '{1, 1, 0, 32'h14, 32'h0, 5'd3, 0, 32'h0BAD_F00D}, '{1, 1, 1, 32'h0BAD_F00D, 0, 0}, land2);
        chk("b2b land spacing", land2 - land1, 2);

        // reset in the middle of a BUSY access, with the load still presented
        RegWriteM = 1; MemtoRegM = 1; ALUOutM = 32'h40; WriteRegM = 5'd7;
        #1 chk("midrst pre StallM", {31'b0, StallM}, 32'h1);
        @(posedge clk); #1;
        chk("midrst mem_req up", {31'b0, mem_req}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst mem_req", {31'b0, mem_req}, 32'h0);
        chk("midrst StallM", {31'b0, StallM}, 32'h0);
        chkWbZero("midrst");
        clearInputs();
        @(posedge clk); #1 rst_n = 1'b1;
        runOne("postrst alu", vecs[0].i, vecs[0].e, tmp);
        runOne("postrst store", vecs[2].i, vecs[2].e, tmp);

        // random instructions against the transaction model
        for (int n = 0; n < 60; n++) begin
            ri.rw    = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       begin ri.mtr = 0; ri.mw = 0; end
                1, 2:    begin ri.mtr = 1; ri.mw = 0; end
                default: begin ri.mtr = 0; ri.mw = 1; end
            endcase
            ri.addr  = $urandom;
            if ($urandom_range(0, 4) != 0) ri.addr[1:0] = 2'b00;
            ri.wdata = $urandom;
            ri.wreg  = 5'($urandom);
            ri.d     = ($urandom_range(0, 3) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 2)
                                                   : $urandom_range(0, 4);
            ri.rdata = $urandom;
            runOne($sformatf("rnd%0d", n), ri, model(ri), tmp);
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErr);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller that sits directly after the EX→MEM pipeline register. It reads that register's outputs (RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM) and runs loads and stores on a req/ack data-memory bus. It stalls the front of the pipeline while an access is outstanding, then writes the result into its own MEM→WB pipeline register. It also detects misaligned accesses and bus timeouts.

## Interface
Parameters:
- TIMEOUT, 16, maximum number of BUSY cycles to wait for mem_ack before a bus error is declared (minimum 2).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- RegWriteM, MemtoRegM, MemWriteM  in  1 each  control bits from the EX→MEM register.
- ALUOutM  in  32  effective address or ALU result.
- WriteDataM  in  32  store data.
- WriteRegM  in  5  destination register.
- mem_req  out  1  bus request, registered.
- mem_we  out  1  1 = store, 0 = load; valid while mem_req = 1.
- mem_addr  out  32  word address; {ALUOutM[31:2],2'b00}, registered.
- mem_wdata  out  32  store data, registered.
- mem_ack  in  1  single-cycle completion from memory.
- mem_rdata  in  32  load data; valid in the mem_ack cycle.
- StallM  out  1  freezes PC, IF/ID, ID/EX and EX→MEM registers while high. Combinational.
- RegWriteW, MemtoRegW  out  1 each  MEM→WB control bits.
- ReadDataW, ALUOutW  out  32 each  MEM→WB data.
- WriteRegW  out  5  MEM→WB destination register.
- AlignErrW, BusErrW  out  1 each  exception flags travelling with the instruction.

## Operation
- access = MemtoRegM | MemWriteM; misaligned = access & (ALUOutM[1:0] != 0).
- FSM states: IDLE, BUSY.
- IDLE:
  - access & !misaligned → StallM = 1. Next edge: state goes to BUSY, mem_req = 1, mem_we = MemWriteM, mem_addr and mem_wdata are latched, timeout counter cleared.
  - Otherwise StallM = 0.
- BUSY, while mem_ack = 0:
  - StallM = 1; the counter increments each cycle.
  - When the counter reaches TIMEOUT-1 without an ack: StallM = 0 for that cycle. On the edge, state goes to IDLE and mem_req drops. MEM→WB loads the instruction with BusErrW = 1, RegWriteW = 0, ReadDataW = 0.
- BUSY with mem_ack = 1:
  - StallM = 0 in that cycle. On the edge, state goes to IDLE and mem_req drops.
  - MEM→WB loads the instruction; ReadDataW = mem_rdata if MemtoRegM, else 0.
  - An ack arriving in the timeout cycle takes priority over the timeout (no error).
- mem_ack in IDLE is ignored.
- MEM→WB register, loaded on posedge:
  - StallM = 0: loads RegWriteM, MemtoRegM, ALUOutM, WriteRegM, the flags, and ReadDataW (0 for non-loads).
  - StallM = 1: loads a bubble (all fields 0), so WB never writes twice.
- Misaligned access: no stall, no request. MEM→WB loads with AlignErrW = 1, RegWriteW = 0, MemtoRegW = 0.
- Non-memory instructions pass through with no stall.
- Upstream holds the EX→MEM outputs constant while StallM = 1. The block does not re-sample the address in BUSY.

## Timing
- Reset (async, rst_n = 0): state IDLE, counter 0. All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, and every *W output. StallM evaluates to 0 in IDLE with no access.
- Reset during BUSY drops mem_req immediately; the outstanding access is abandoned.
- Non-memory instruction: 1-cycle latency EX→MEM to MEM→WB.
- Memory access with ack on the first BUSY cycle: 2 cycles in M (IDLE detect + BUSY). Each extra wait cycle adds 1.
- Timeout: exactly TIMEOUT BUSY cycles, then release.
- Back-to-back memory instructions: each new access starts its own IDLE-detect cycle. mem_req is low for at least 1 cycle between requests.

## Test plan
- Reset check: assert rst_n = 0 mid-BUSY → mem_req = 0 immediately, StallM = 0, all *W outputs = 0; after release, state is IDLE.
- ALU op: RegWriteM = 1, ALUOutM = 0x0000_1234, WriteRegM = 8 → StallM never 1; next edge RegWriteW = 1, ALUOutW = 0x1234, WriteRegW = 8.
- Load: MemtoRegM = 1, ALUOutM = 0x100; memory acks after 3 BUSY cycles with rdata = 0xDEAD_BEEF →
  - StallM high for 4 cycles;
  - mem_addr = 0x100, mem_we = 0;
  - ReadDataW = 0xDEADBEEF, MemtoRegW = 1;
  - bubbles (RegWriteW = 0) during the stall.
- Store: MemWriteM = 1, ALUOutM = 0x204, WriteDataM = 0x55AA55AA, ack on first BUSY cycle → mem_we = 1, mem_wdata = 0x55AA55AA, 2-cycle stay in M, RegWriteW = 0.
- Misaligned and timeout:
  - Load at ALUOutM = 0x102 → no mem_req, AlignErrW = 1, RegWriteW = 0.
  - Load at 0x300 with no ack and TIMEOUT = 16 → StallM high for exactly 16 cycles, then BusErrW = 1.
- Back-to-back: store at 0x10 followed by load at 0x14, both acked immediately → two separate mem_req pulses separated by 1 low cycle; the load result lands in WB 2 cycles after the store.
